intr_ctrl: RTL and testbench

Prioritised, memory-mapped interrupt controller that sequences exception entry for the MIPS core. It collects rising edges from up to NSRC sources (timer flag, debounced buttons, coprocessor done), masks and prioritises them, and drives the core's interrupt request and vector address. It holds the request until the core acknowledges entry, then blocks further requests until software signals end-of-interrupt. It sits beside the timer on the same 5-bit I/O address decode.

---
 rtl/intr_ctrl_pkg.sv | 28 ++
 rtl/intr_pending.sv | 35 +++
 rtl/intr_ctrl.sv | 127 ++++++++++++
 tb/tb_intr_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding,
// default vector layout and the priority helper.
package intr_ctrl_pkg;

  localparam int unsigned IDXW = 3;

  localparam logic [31:0] VBASE_DEF   = 32'h0000_0180;
  localparam logic [31:0] VSTRIDE_DEF = 32'h0000_0020;

  localparam logic [4:0] A_MASK = 5'b11000;
  localparam logic [4:0] A_PEND = 5'b11001;
  localparam logic [4:0] A_STAT = 5'b11010;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StSvc  = 2'b10
  } state_e;

  // Index of the lowest set bit; source 0 has the highest priority.
  function automatic logic [IDXW-1:0] lowest_idx(input logic [7:0] v);
    lowest_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDXW'(i);
    end
  endfunction

endpackage

// File: rtl/intr_pending.sv
// Rising-edge capture and sticky pending bits; a new edge beats a clear on the
// same bit in the same cycle.
module intr_pending #(
  parameter int unsigned NSRC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic [NSRC-1:0] clr,
  output logic [NSRC-1:0] pend,
  output logic [NSRC-1:0] pend_next
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] rise;

  always_comb begin
    rise      = src & ~src_q;
    pend_next = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src;
      pend_q <= pend_next;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: masks pending events, raises irq with a
// per-source vector, and blocks further requests until end-of-interrupt.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned NSRC    = 4,
  parameter logic [31:0] VBASE   = VBASE_DEF,
  parameter logic [31:0] VSTRIDE = VSTRIDE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq,
  output logic [31:0]     vec_addr,
  input  logic            ack,
  input  logic            eoi,
  output logic            in_service
);

  state_e          state_q;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            gie_q, gie_d;
  logic [IDXW-1:0] idx_q, nxt_idx;
  logic            irq_q, svc_q;
  logic [31:0]     vec_q, vec_next;
  logic [NSRC-1:0] pend, pend_next, clr, cand, sel;
  logic            wr_mask, wr_pend, wr_stat, withdraw;
  logic            unused_wdata;

  assign unused_wdata = ^wdata;

  intr_pending #(
    .NSRC(NSRC)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .clr      (clr),
    .pend     (pend),
    .pend_next(pend_next)
  );

  always_comb begin
    wr_mask  = we && (addr == A_MASK);
    wr_pend  = we && (addr == A_PEND);
    wr_stat  = we && (addr == A_STAT);
    mask_d   = wr_mask ? wdata[NSRC-1:0] : mask_q;
    gie_d    = wr_stat ? wdata[0] : gie_q;
    sel      = NSRC'(1) << idx_q;
    clr      = wr_pend ? wdata[NSRC-1:0] : '0;
    if (state_q == StReq && ack) clr = clr | sel;
    cand     = pend & mask_q;
    nxt_idx  = lowest_idx(8'(cand));
    vec_next = VBASE + VSTRIDE * 32'(nxt_idx);
    // Judged on next-cycle values so irq falls the cycle after the withdrawing write.
    withdraw = !(|(pend_next & sel)) || !(|(mask_d & sel)) || !gie_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      gie_q   <= 1'b0;
      idx_q   <= '0;
      irq_q   <= 1'b0;
      svc_q   <= 1'b0;
      vec_q   <= VBASE;
    end else begin
      mask_q <= mask_d;
      gie_q  <= gie_d;
      unique case (state_q)
        StIdle: begin
          if (gie_q && |cand) begin
            idx_q   <= nxt_idx;
            vec_q   <= vec_next;
            irq_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (ack) begin
            irq_q   <= 1'b0;
            svc_q   <= 1'b1;
            state_q <= StSvc;
          end else if (withdraw) begin
            irq_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        StSvc: begin
          if (eoi) begin
            svc_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          svc_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_MASK: rdata[NSRC-1:0] = mask_q;
      A_PEND: rdata[NSRC-1:0] = pend;
      A_STAT: begin
        rdata[0]    = gie_q;
        rdata[2:1]  = state_q;
        rdata[10:8] = idx_q;
      end
      default: rdata = '0;
    endcase
  end

  assign irq        = irq_q;
  assign in_service = svc_q;
  assign vec_addr   = vec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed and random checks of intr_ctrl against a cycle-level behavioural model.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  localparam int unsigned NSRC = 4;
  localparam logic [31:0] VB   = 32'h0000_0180;
  localparam logic [31:0] VS   = 32'h0000_0020;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            we;
  logic [4:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq;
  logic [31:0]     vec_addr;
  logic            ack;
  logic            eoi;
  logic            in_service;

  int tests = 0;
  int fails = 0;

  // Model: requesting / servicing flags, pending and mask as plain integers.
  int          m_mask, m_pend, m_gie, m_prev, m_idx;
  bit          m_req, m_svc;
  logic [31:0] m_vec;

  intr_ctrl #(
    .NSRC   (NSRC),
    .VBASE  (VB),
    .VSTRIDE(VS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq),
    .vec_addr  (vec_addr),
    .ack       (ack),
    .eoi       (eoi),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_gie = 0; m_prev = 0; m_idx = 0;
    m_req = 0; m_svc = 0; m_vec = VB;
  endtask

  task automatic model_step();
    int rise, w1c, nm, ng, ackclr, pn;
    rise   = int'(src) & ~m_prev & 'hF;
    nm     = (we && addr == A_MASK) ? int'(wdata[3:0]) : m_mask;
    ng     = (we && addr == A_STAT) ? int'(wdata[0]) : m_gie;
    w1c    = (we && addr == A_PEND) ? int'(wdata[3:0]) : 0;
    ackclr = 0;
    if (m_req) begin
      if (ack) begin
        ackclr = 1 << m_idx;
        m_req  = 0;
        m_svc  = 1;
      end else begin
        pn = (m_pend & ~w1c) | rise;
        if (((pn >> m_idx) & 1) == 0 || ((nm >> m_idx) & 1) == 0 || ng == 0) m_req = 0;
      end
    end else if (m_svc) begin
      if (eoi) m_svc = 0;
    end else if (m_gie != 0 && (m_pend & m_mask) != 0) begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (((m_pend & m_mask) >> i) & 1) m_idx = i;
      end
      m_req = 1;
      m_vec = VB + VS * m_idx;
    end
    m_pend = ((m_pend & ~w1c & ~ackclr) | rise) & 'hF;
    m_mask = nm;
    m_gie  = ng;
    m_prev = int'(src);
  endtask

  function automatic logic [31:0] exp_rdata();
    int st;
    st = m_req ? 1 : (m_svc ? 2 : 0);
    case (addr)
      A_MASK:  return 32'(m_mask);
      A_PEND:  return 32'(m_pend);
      A_STAT:  return 32'((m_idx << 8) | (st << 1) | m_gie);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_all();
    check("irq", {31'b0, irq}, {31'b0, m_req});
    check("in_service", {31'b0, in_service}, {31'b0, m_svc});
    if (m_req) check("vec_addr", vec_addr, m_vec);
    check("rdata", rdata, exp_rdata());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic pulse_src(input logic [NSRC-1:0] s);
    src = s; tick(); src = '0; tick();
  endtask

  initial begin
    logic [4:0] raddr [4];
    raddr = '{A_MASK, A_PEND, A_STAT, 5'h03};
    rst = 1'b1; src = '0; we = 1'b0; addr = A_PEND; wdata = '0; ack = 1'b0; eoi = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_vec", vec_addr, 32'h180);
    check("reset_pend", rdata, 32'h0);
    rst = 1'b0;

    // Single source, full handshake.
    wr(A_MASK, 32'hF);
    wr(A_STAT, 32'h1);
    addr = A_PEND;
    src = 4'b0100; tick();
    check("pend_set", rdata, 32'h4);
    check("irq_not_yet", {31'b0, irq}, 32'h0);
    src = '0; tick();
    check("irq_2cyc", {31'b0, irq}, 32'h1);
    check("vec_src2", vec_addr, 32'h1C0);
    pulse_ack();
    check("pend_cleared", rdata, 32'h0);
    check("svc_after_ack", {31'b0, in_service}, 32'h1);
    pulse_eoi();

    // Simultaneous sources served in priority order.
    src = 4'b1010; tick(); src = '0; tick();
    check("vec_src1_first", vec_addr, 32'h1A0);
    pulse_ack();
    pulse_eoi();
    tick();
    check("irq_second", {31'b0, irq}, 32'h1);
    check("vec_src3_second", vec_addr, 32'h1E0);
    pulse_ack();
    pulse_eoi();

    // Masked source stays pending until unmasked.
    wr(A_MASK, 32'h1);
    addr = A_PEND;
    pulse_src(4'b0010);
    check("masked_pend", rdata, 32'h2);
    check("masked_no_irq", {31'b0, irq}, 32'h0);
    wr(A_MASK, 32'h3);
    tick();
    check("unmask_irq", {31'b0, irq}, 32'h1);
    check("unmask_vec", vec_addr, 32'h1A0);
    pulse_ack();
    pulse_eoi();

    // Withdrawal by W1C while requesting.
    pulse_src(4'b0001);
    check("req_src0", {31'b0, irq}, 32'h1);
    wr(A_PEND, 32'h1);
    check("withdraw_irq", {31'b0, irq}, 32'h0);
    addr = A_STAT; #1;
    check("withdraw_status", rdata, 32'h1);

    // Event during service waits for eoi; stray eoi in idle is ignored.
    pulse_src(4'b0001);
    pulse_ack();
    pulse_src(4'b0001);
    check("svc_blocks_irq", {31'b0, irq}, 32'h0);
    pulse_eoi();
    check("eoi_idle_irq", {31'b0, irq}, 32'h0);
    tick();
    check("post_eoi_irq", {31'b0, irq}, 32'h1);
    pulse_ack();
    pulse_eoi();
    pulse_eoi();
    check("stray_eoi_status", rdata, 32'h1);
    check("stray_eoi_svc", {31'b0, in_service}, 32'h0);

    // Reset while in service with events pending.
    wr(A_MASK, 32'hF);
    pulse_src(4'b0001);
    pulse_ack();
    addr = A_PEND;
    pulse_src(4'b0110);
    check("pre_rst_pend", rdata, 32'h6);
    rst = 1'b1; #1;
    model_reset();
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_svc", {31'b0, in_service}, 32'h0);
    check("rst_vec", vec_addr, 32'h180);
    check("rst_pend", rdata, 32'h0);
    addr = A_MASK; #1;
    check("rst_mask", rdata, 32'h0);
    rst = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      src   = NSRC'($urandom);
      ack   = ($urandom_range(3) == 0);
      eoi   = ($urandom_range(3) == 0);
      we    = ($urandom_range(5) == 0);
      addr  = raddr[$urandom_range(3)];
      wdata = $urandom;
      if (addr == A_STAT) wdata[0] = ($urandom_range(4) != 0);
      if (addr == A_PEND && $urandom_range(1) == 0) wdata[3:0] = 4'h0;
      tick();
    end
    ack = 1'b0; eoi = 1'b0; we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
